music_player: RTL

MUSIC_PLAYER -- requirements
Module: music_player

---
 rtl/music_player_pkg.sv | 31 +++
 rtl/music_player_tone_gen.sv | 50 +++++
 rtl/music_player.sv | 134 +++++++++++++
 3 files changed

// File: rtl/music_player_pkg.sv
// Shared types and score constants for the music player.
// Note values are half-periods in 50 MHz clocks; durations are in eighth-note units.
package music_player_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StPlay
  } state_e;

  localparam int unsigned EIGHTH        = 1;
  localparam int unsigned QUARTER       = 2;
  localparam int unsigned QUARTEREIGHTH = 3;
  localparam int unsigned HALF          = 4;
  localparam int unsigned ONE           = 8;
  localparam int unsigned TWO           = 16;

  localparam int unsigned C4 = 95556;
  localparam int unsigned D4 = 85131;
  localparam int unsigned E4 = 75843;
  localparam int unsigned F4 = 71586;
  localparam int unsigned G4 = 63776;
  localparam int unsigned A4 = 56818;
  localparam int unsigned B4 = 50619;
  localparam int unsigned C5 = 47778;
  localparam int unsigned D5 = 42566;

  // Any half-period at or below this value is a rest.
  localparam int unsigned SP = 1;

endpackage

// File: rtl/music_player_tone_gen.sv
// Square-wave tone generator: toggles its phase every note_i enabled clocks.
// The output is gated low while disabled or when the note is a rest.
module tone_gen
  import music_player_pkg::*;
#(
  parameter int unsigned NOTE_W = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [NOTE_W-1:0] note_i,
  output logic              speaker_o
);

  logic [NOTE_W-1:0] cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic              rest;

  assign rest = (note_i <= NOTE_W'(SP));

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clear_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (en_i && !rest) begin
      if (cnt_q == note_i - NOTE_W'(1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + NOTE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign speaker_o = phase_q & en_i & ~rest;

endmodule

// File: rtl/music_player.sv
// Score sequencer: walks an external score table, playing each note for its
// duration through tone_gen, with pause, stop and optional looping.
module music_player
  import music_player_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned NOTE_W       = 20,
  parameter int unsigned DUR_W        = 5,
  parameter int unsigned EIGHTH_TICKS = 12_500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] last_idx,
  output logic [ADDR_W-1:0] score_addr,
  input  logic [NOTE_W-1:0] score_note,
  input  logic [DUR_W-1:0]  score_dur,
  output logic              speaker,
  output logic              busy,
  output logic              done
);

  // Wide enough for the longest note, (2^DUR_W - 1) eighths, without wrapping.
  localparam int unsigned CntW = DUR_W + $clog2(EIGHTH_TICKS + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [CntW-1:0]   dur_cnt_q, dur_cnt_d;
  logic              done_q, done_d;

  logic [DUR_W-1:0]  dur_eff;
  logic [CntW-1:0]   dur_last;
  logic              play_en;
  logic              note_end;
  logic              tone_clear;

  assign dur_eff    = (dur_q == '0) ? DUR_W'(1) : dur_q;
  assign dur_last   = CntW'(dur_eff) * CntW'(EIGHTH_TICKS) - CntW'(1);
  assign play_en    = (state_q == StPlay) && !pause;
  assign note_end   = play_en && (dur_cnt_q == dur_last);
  assign tone_clear = (state_q == StFetch);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    note_d    = note_q;
    dur_d     = dur_q;
    dur_cnt_d = dur_cnt_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d = StFetch;
          addr_d  = '0;
        end
      end
      StFetch: begin
        if (stop) begin
          state_d = StIdle;
          addr_d  = '0;
        end else begin
          note_d    = score_note;
          dur_d     = score_dur;
          dur_cnt_d = '0;
          state_d   = StPlay;
        end
      end
      StPlay: begin
        if (stop) begin
          state_d = StIdle;
          addr_d  = '0;
        end else if (note_end) begin
          // >= keeps the index from running away if last_idx shrank mid-song.
          if (addr_q < last_idx) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StFetch;
          end else if (loop_en) begin
            addr_d  = '0;
            state_d = StFetch;
          end else begin
            addr_d  = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end else if (play_en) begin
          dur_cnt_d = dur_cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      note_q    <= '0;
      dur_q     <= '0;
      dur_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      note_q    <= note_d;
      dur_q     <= dur_d;
      dur_cnt_q <= dur_cnt_d;
      done_q    <= done_d;
    end
  end

  tone_gen #(
    .NOTE_W(NOTE_W)
  ) u_tone_gen (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (tone_clear),
    .en_i     (play_en),
    .note_i   (note_q),
    .speaker_o(speaker)
  );

  assign score_addr = addr_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;

endmodule
